// File: rtl/sb_access_initiator.sv
// Debug-side system bus initiator: runs one sized read/write per command on the shared bus
// and returns a single response carrying read data or an error code.
module sb_access_initiator #(
  parameter int unsigned DataWidth        = 32,
  parameter int unsigned ByteAddressWidth = 32,
  parameter int unsigned ByteSize         = 8,
  parameter int unsigned TimeoutCycles    = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [1:0]                      cmd_size,
  input  logic [ByteAddressWidth-1:0]     cmd_address,
  input  logic                            cmd_use_last,
  input  logic                            cmd_autoincrement,
  input  logic [DataWidth-1:0]            cmd_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DataWidth-1:0]            rsp_rdata,
  output logic [1:0]                      rsp_error,
  output logic [ByteAddressWidth-1:0]     next_address,
  output logic [ByteAddressWidth-1:0]     bus_address,
  output logic                            bus_read,
  output logic                            bus_write,
  output logic [DataWidth/ByteSize-1:0]   bus_byte_enable,
  output logic [DataWidth-1:0]            bus_write_data,
  input  logic [DataWidth-1:0]            bus_read_data,
  input  logic                            bus_available
);

  localparam int unsigned Lanes      = DataWidth / ByteSize;
  localparam int unsigned LaneBits   = $clog2(Lanes);
  localparam int unsigned CntWidth   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned StallLimit = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic        TimeoutEn  = (TimeoutCycles != 0);

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrAlign   = 2'd1;
  localparam logic [1:0] ErrSize    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

  state_e                        state_q, state_d;
  logic                          write_q, write_d;
  logic                          autoinc_q, autoinc_d;
  logic [3:0]                    bytes_q, bytes_d;
  logic [ByteAddressWidth-1:0]   addr_q, addr_d;
  logic [CntWidth-1:0]           stall_q, stall_d;

  logic                          cmd_ready_d, rsp_valid_d, bus_read_d, bus_write_d;
  logic [DataWidth-1:0]          rsp_rdata_d, bus_write_data_d;
  logic [1:0]                    rsp_error_d;
  logic [ByteAddressWidth-1:0]   next_address_d, bus_address_d;
  logic [Lanes-1:0]              bus_byte_enable_d;

  logic [ByteAddressWidth-1:0]   eff_addr;
  logic [LaneBits-1:0]           eff_lane;
  logic [3:0]                    cmd_bytes;
  logic                          bad_size, misaligned, handshake;
  logic [Lanes-1:0]              lane_mask;
  logic [DataWidth-1:0]          rdata_shifted, rdata_mask;

  // Command decode: effective address, sizing and lane placement
  assign handshake     = cmd_valid && cmd_ready;
  assign eff_addr      = cmd_use_last ? next_address : cmd_address;
  assign eff_lane      = eff_addr[LaneBits-1:0];
  assign cmd_bytes     = 4'd1 << cmd_size;
  assign bad_size      = (cmd_size == 2'd3) || (32'(cmd_bytes) > Lanes);
  assign misaligned    = |(eff_lane & LaneBits'(cmd_bytes - 4'd1));
  assign lane_mask     = Lanes'((16'd1 << cmd_bytes) - 16'd1);
  assign rdata_shifted = bus_read_data >> (32'(addr_q[LaneBits-1:0]) * ByteSize);
  assign rdata_mask    = ~({DataWidth{1'b1}} << (32'(bytes_q) * ByteSize));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      write_q         <= 1'b0;
      autoinc_q       <= 1'b0;
      bytes_q         <= '0;
      addr_q          <= '0;
      stall_q         <= '0;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_error       <= '0;
      next_address    <= '0;
      bus_address     <= '0;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
      bus_byte_enable <= '0;
      bus_write_data  <= '0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      autoinc_q       <= autoinc_d;
      bytes_q         <= bytes_d;
      addr_q          <= addr_d;
      stall_q         <= stall_d;
      cmd_ready       <= cmd_ready_d;
      rsp_valid       <= rsp_valid_d;
      rsp_rdata       <= rsp_rdata_d;
      rsp_error       <= rsp_error_d;
      next_address    <= next_address_d;
      bus_address     <= bus_address_d;
      bus_read        <= bus_read_d;
      bus_write       <= bus_write_d;
      bus_byte_enable <= bus_byte_enable_d;
      bus_write_data  <= bus_write_data_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    write_d           = write_q;
    autoinc_d         = autoinc_q;
    bytes_d           = bytes_q;
    addr_d            = addr_q;
    stall_d           = stall_q;
    rsp_valid_d       = rsp_valid;
    rsp_rdata_d       = rsp_rdata;
    rsp_error_d       = rsp_error;
    next_address_d    = next_address;
    bus_address_d     = bus_address;
    bus_read_d        = bus_read;
    bus_write_d       = bus_write;
    bus_byte_enable_d = bus_byte_enable;
    bus_write_data_d  = bus_write_data;

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          write_d   = cmd_write;
          autoinc_d = cmd_autoincrement;
          bytes_d   = cmd_bytes;
          addr_d    = eff_addr;
          stall_d   = '0;
          if (bad_size || misaligned) begin
            // Rejected commands answer directly without touching the bus
            state_d     = RESPOND;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_error_d = bad_size ? ErrSize : ErrAlign;
          end else begin
            state_d           = ACCESS;
            bus_read_d        = !cmd_write;
            bus_write_d       = cmd_write;
            bus_address_d     = eff_addr & ~ByteAddressWidth'(Lanes - 1);
            bus_byte_enable_d = lane_mask << eff_lane;
            bus_write_data_d  = cmd_wdata << (32'(eff_lane) * ByteSize);
          end
        end
      end
      ACCESS: begin
        // Availability on the limit cycle wins over the timeout
        if (bus_available || (TimeoutEn && (stall_q == CntWidth'(StallLimit)))) begin
          state_d           = RESPOND;
          rsp_valid_d       = 1'b1;
          bus_read_d        = 1'b0;
          bus_write_d       = 1'b0;
          bus_address_d     = '0;
          bus_byte_enable_d = '0;
          bus_write_data_d  = '0;
          if (bus_available) begin
            rsp_error_d    = ErrOk;
            rsp_rdata_d    = write_q ? '0 : (rdata_shifted & rdata_mask);
            next_address_d = autoinc_q ? (addr_q + ByteAddressWidth'(bytes_q)) : addr_q;
          end else begin
            rsp_error_d = ErrTimeout;
            rsp_rdata_d = '0;
          end
        end else begin
          stall_d = stall_q + CntWidth'(1);
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_sb_access_initiator.sv
// Directed bench for sb_access_initiator: expected responses are queued at command issue
// and compared when the DUT presents them; bus-side behaviour is checked cycle by cycle.
module tb_sb_access_initiator;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_use_last, cmd_autoincrement;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_address, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_error;
  logic [31:0] next_address, bus_address, bus_write_data, bus_read_data;
  logic        bus_read, bus_write, bus_available;
  logic [3:0]  bus_byte_enable;

  int checks = 0;
  int errors = 0;
  int bus_cycles = 0;
  logic [33:0] exp_q[$];

  sb_access_initiator #(
    .DataWidth(32), .ByteAddressWidth(32), .ByteSize(8), .TimeoutCycles(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_address(cmd_address), .cmd_use_last(cmd_use_last),
    .cmd_autoincrement(cmd_autoincrement), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .next_address(next_address),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_byte_enable(bus_byte_enable), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .bus_available(bus_available)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus_read || bus_write) bus_cycles++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_rsp(input logic [1:0] err, input logic [31:0] rdata);
    exp_q.push_back({err, rdata});
  endtask

  // Offers one command and returns one cycle after the handshake edge
  task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic use_last, input logic inc, input logic [31:0] wd);
    int n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    chk("cmd_ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_address = addr;
    cmd_use_last = use_last; cmd_autoincrement = inc; cmd_wdata = wd;
    step();
    cmd_valid = 1'b0;
  endtask

  // Waits for a response, optionally stalls it, then compares against the scoreboard
  task automatic get_rsp(input string tag, input int hold, output int lat);
    logic [33:0] e;
    lat = 1;
    while (!rsp_valid && lat < 40) begin step(); lat++; end
    chk({tag, "_valid"}, rsp_valid, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_rdata"}, rsp_rdata, e[31:0]);
      chk({tag, "_hold_cmd_ready"}, cmd_ready, 0);
      step();
    end
    chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
    chk({tag, "_error"}, rsp_error, e[33:32]);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, rsp_valid, 0);
    chk({tag, "_cmd_ready_after"}, cmd_ready, 1);
  endtask

  initial begin
    int lat;
    int b0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
    cmd_address = '0; cmd_use_last = 1'b0; cmd_autoincrement = 1'b0; cmd_wdata = '0;
    rsp_ready = 1'b0; bus_read_data = '0; bus_available = 1'b1;

    step(); step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_next_address", next_address, 0);
    chk("rst_bus", {bus_read, bus_write, bus_byte_enable, bus_address, bus_write_data}, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Word read, bus immediately available
    b0 = bus_cycles;
    bus_read_data = 32'hDEADBEEF;
    expect_rsp(2'd0, 32'hDEADBEEF);
    send(1'b0, 2'd2, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("t1_bus_read", bus_read, 1);
    chk("t1_bus_write", bus_write, 0);
    chk("t1_bus_address", bus_address, 32'h100);
    chk("t1_byte_enable", bus_byte_enable, 4'b1111);
    chk("t1_rsp_early", rsp_valid, 0);
    get_rsp("t1", 0, lat);
    chk("t1_latency", lat, 2);
    chk("t1_bus_cycles", bus_cycles - b0, 1);
    chk("t1_next_address", next_address, 32'h100);

    // Byte write to the top lane
    expect_rsp(2'd0, 32'h0);
    send(1'b1, 2'd0, 32'h203, 1'b0, 1'b0, 32'h000000A5);
    chk("t2_bus_write", bus_write, 1);
    chk("t2_bus_read", bus_read, 0);
    chk("t2_bus_address", bus_address, 32'h200);
    chk("t2_byte_enable", bus_byte_enable, 4'b1000);
    chk("t2_write_data", bus_write_data, 32'hA5000000);
    get_rsp("t2", 0, lat);
    chk("t2_next_address", next_address, 32'h203);

    // Half read from the upper half
    bus_read_data = 32'h12345678;
    expect_rsp(2'd0, 32'h00001234);
    send(1'b0, 2'd1, 32'h202, 1'b0, 1'b0, 32'h0);
    chk("t3_bus_address", bus_address, 32'h200);
    chk("t3_byte_enable", bus_byte_enable, 4'b1100);
    get_rsp("t3", 0, lat);

    // Read issued during a 4-cycle bus stall, completes on the first available cycle
    b0 = bus_cycles;
    bus_available = 1'b0;
    bus_read_data = 32'h0;
    expect_rsp(2'd0, 32'hCAFEF00D);
    send(1'b0, 2'd2, 32'h40, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_stall_read", bus_read, 1);
      chk("t4_stall_addr", bus_address, 32'h40);
      chk("t4_stall_be", bus_byte_enable, 4'b1111);
      chk("t4_stall_rsp", rsp_valid, 0);
      step();
    end
    bus_available = 1'b1;
    bus_read_data = 32'hCAFEF00D;
    chk("t4_read_still_high", bus_read, 1);
    get_rsp("t4", 0, lat);
    chk("t4_latency", lat, 2);
    chk("t4_bus_cycles", bus_cycles - b0, 5);
    chk("t4_next_address", next_address, 32'h40);

    // Misaligned half and invalid size: immediate error, no bus activity
    b0 = bus_cycles;
    expect_rsp(2'd1, 32'h0);
    send(1'b0, 2'd1, 32'h101, 1'b0, 1'b1, 32'h0);
    get_rsp("t5_misaligned", 0, lat);
    chk("t5_latency", lat, 1);
    expect_rsp(2'd2, 32'h0);
    send(1'b1, 2'd3, 32'h100, 1'b0, 1'b1, 32'hFFFFFFFF);
    get_rsp("t5_badsize", 0, lat);
    chk("t5_badsize_latency", lat, 1);
    chk("t5_bus_cycles", bus_cycles - b0, 0);
    chk("t5_next_address", next_address, 32'h40);

    // Bus stuck unavailable: abort after 8 stall cycles
    b0 = bus_cycles;
    bus_available = 1'b0;
    expect_rsp(2'd3, 32'h0);
    send(1'b0, 2'd2, 32'h300, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("t6_read_held", bus_read, 1);
      step();
    end
    chk("t6_read_dropped", bus_read, 0);
    get_rsp("t6", 0, lat);
    chk("t6_latency", lat, 1);
    chk("t6_bus_cycles", bus_cycles - b0, 8);
    chk("t6_next_address", next_address, 32'h40);

    // Availability on the limit cycle completes the access instead of timing out
    expect_rsp(2'd0, 32'h0BADF00D);
    send(1'b0, 2'd2, 32'h304, 1'b0, 1'b0, 32'h0);
    repeat (7) step();
    chk("t7_read_held", bus_read, 1);
    bus_available = 1'b1;
    bus_read_data = 32'h0BADF00D;
    get_rsp("t7", 0, lat);
    chk("t7_next_address", next_address, 32'h304);

    // Auto-increment across the address wrap, with a stalled response
    bus_read_data = 32'h11111111;
    expect_rsp(2'd0, 32'h11111111);
    send(1'b0, 2'd2, 32'hFFFFFFF8, 1'b0, 1'b1, 32'h0);
    chk("t8_addr0", bus_address, 32'hFFFFFFF8);
    get_rsp("t8_r0", 0, lat);
    chk("t8_next0", next_address, 32'hFFFFFFFC);
    bus_read_data = 32'h22222222;
    expect_rsp(2'd0, 32'h22222222);
    send(1'b0, 2'd2, 32'h12345678, 1'b1, 1'b1, 32'h0);
    chk("t8_addr1", bus_address, 32'hFFFFFFFC);
    get_rsp("t8_r1", 3, lat);
    chk("t8_next1", next_address, 32'h0);
    bus_read_data = 32'h33333333;
    expect_rsp(2'd0, 32'h33333333);
    send(1'b0, 2'd2, 32'h12345678, 1'b1, 1'b1, 32'h0);
    chk("t8_addr2", bus_address, 32'h0);
    get_rsp("t8_r2", 0, lat);
    chk("t8_next2", next_address, 32'h4);

    // Reset in the middle of an access drops it without a response
    bus_available = 1'b0;
    send(1'b0, 2'd2, 32'h500, 1'b0, 1'b0, 32'h0);
    chk("t9_read_before_rst", bus_read, 1);
    rst_n = 1'b0;
    step();
    chk("t9_bus_after_rst", {bus_read, bus_write}, 0);
    chk("t9_rsp_after_rst", rsp_valid, 0);
    chk("t9_cmd_ready_in_rst", cmd_ready, 0);
    chk("t9_next_address_rst", next_address, 0);
    rst_n = 1'b1;
    bus_available = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t9_no_rsp", rsp_valid, 0);
    end
    chk("t9_cmd_ready", cmd_ready, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
